// File: rtl/gpu_frame_scheduler.sv
// Frame sequencer: latches staged frame config, runs GPU transform/raster phases,
// reports completion/statistics and gates host vertex writes while vertices are being read.
module gpu_frame_scheduler #(
  parameter int unsigned M         = 11,
  parameter int unsigned N         = 7,
  parameter int unsigned AW        = 14,
  parameter int unsigned XFORM_LAT = 16,
  parameter int unsigned TIMEOUT   = 2**24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         cfg_vertex_count,
  input  logic                cfg_mat_wr_en,
  input  logic [3:0]          cfg_mat_wr_idx,
  input  logic signed [M+N-1:0] cfg_mat_wr_data,
  input  logic                frame_req,
  output logic                frame_ack,
  input  logic                host_wr_en,
  input  logic [AW-1:0]       host_wr_addr,
  input  logic [M+N-1:0]      host_wr_data,
  output logic                host_wr_ready,
  output logic                mem_wr_en,
  output logic [AW-1:0]       mem_wr_addr,
  output logic [M+N-1:0]      mem_wr_data,
  output logic [31:0]         gpu_vertex_count,
  output logic                gpu_start,
  output logic signed [M+N-1:0] transform_matrix [0:15],
  input  logic                frame_end,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_error,
  output logic [15:0]         frame_cnt,
  output logic [31:0]         last_frame_cycles
);

  localparam int unsigned W = M + N;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StStart,
    StTransform,
    StRaster,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic signed [W-1:0] stage_q [16];
  logic signed [W-1:0] mat_q   [16];

  logic [31:0] gvc_q, gvc_d;
  logic [31:0] masked_count;
  logic [32:0] xform_q, xform_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic          wr_accept;
  logic          mem_en_q;
  logic [AW-1:0] mem_addr_q;
  logic [W-1:0]  mem_data_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign masked_count = cfg_vertex_count & 32'hFFFF_FFFC;

  // Staging registers accept host config writes in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) stage_q[i] <= '0;
    end else if (cfg_mat_wr_en) begin
      stage_q[cfg_mat_wr_idx] <= cfg_mat_wr_data;
    end
  end

  // A staging write coinciding with the latch cycle is forwarded into the active copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mat_q[i] <= '0;
    end else if (state_q == StLatch) begin
      for (int i = 0; i < 16; i++) begin
        mat_q[i] <= (cfg_mat_wr_en && (cfg_mat_wr_idx == 4'(i))) ? cfg_mat_wr_data : stage_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      gvc_q   <= '0;
      xform_q <= '0;
      wd_q    <= '0;
      cyc_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gvc_q   <= gvc_d;
      xform_q <= xform_d;
      wd_q    <= wd_d;
      cyc_q   <= cyc_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Cycle counter spans START..last RASTER cycle; DONE adds the final cycle when reported.
  always_comb begin
    state_d = state_q;
    gvc_d   = gvc_q;
    xform_d = xform_q;
    wd_d    = wd_q;
    cyc_d   = cyc_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        cyc_d = '0;
        if (frame_req) state_d = StLatch;
      end
      StLatch: begin
        gvc_d = masked_count;
        if (masked_count == 32'd0) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          err_d   = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        xform_d = {1'b0, gvc_q} + 33'(XFORM_LAT);
        cyc_d   = 32'd1;
        wd_d    = '0;
        state_d = StTransform;
      end
      StTransform: begin
        xform_d = xform_q - 33'd1;
        cyc_d   = sat_inc(cyc_q);
        if (xform_q <= 33'd1) state_d = StRaster;
      end
      StRaster: begin
        cyc_d = sat_inc(cyc_q);
        if (frame_end) begin
          state_d = StDone;
        end else if (wd_q >= 32'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      StDone: begin
        last_d = sat_inc(cyc_q);
        if (!err_q) cnt_d = cnt_q + 16'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Vertex memory is closed to the host while the transform stage may read it.
  assign host_wr_ready = reset &
                         ((state_q == StIdle) || (state_q == StRaster) || (state_q == StDone));
  assign wr_accept     = host_wr_en & host_wr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_en_q <= wr_accept;
      if (wr_accept) begin
        mem_addr_q <= host_wr_addr;
        mem_data_q <= host_wr_data;
      end
    end
  end

  assign mem_wr_en         = mem_en_q;
  assign mem_wr_addr       = mem_addr_q;
  assign mem_wr_data       = mem_data_q;
  assign frame_ack         = (state_q == StLatch);
  assign gpu_start         = (state_q == StStart);
  assign frame_done        = (state_q == StDone);
  assign frame_error       = (state_q == StDone) & err_q;
  assign busy              = (state_q != StIdle);
  assign gpu_vertex_count  = gvc_q;
  assign frame_cnt         = cnt_q;
  assign last_frame_cycles = last_q;
  assign transform_matrix  = mat_q;

endmodule

// File: doc/gpu_frame_scheduler.md
Name: gpu_frame_scheduler

Overview:
- Sequences one render frame through the GPU pipeline: vertex transform, then rasterization.
- Holds the host's staged frame configuration (vertex count, 4x4 transform matrix) and presents it to the GPU as stable active values for the whole frame.
- Issues the single-cycle GPU start pulse, tracks transform and raster phases, and reports completion, errors and statistics.
- Arbitrates the host's vertex-memory write port so vertex data is never overwritten while the transform stage is reading it.

Parameters:
- M, 11, integer bits of fixed-point vertex/matrix words
- N, 7, fractional bits of fixed-point vertex/matrix words
- AW, 14, vertex memory address width (depth 16384)
- XFORM_LAT, 16, cycles added after the last vertex read to cover vertex processor pipeline drain
- TIMEOUT, 2**24, raster-phase watchdog limit in cycles

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_vertex_count  in  32  staged vertex count; sampled at frame latch
- cfg_mat_wr_en  in  1  staged matrix element write strobe
- cfg_mat_wr_idx  in  4  staged matrix element index, 0..15
- cfg_mat_wr_data  in  M+N  staged matrix element, signed
- frame_req  in  1  level request to render one frame
- frame_ack  out  1  one-cycle pulse: request accepted
- host_wr_en  in  1  host vertex memory write request
- host_wr_addr  in  AW  host vertex memory write address
- host_wr_data  in  M+N  host vertex memory write data
- host_wr_ready  out  1  host write accepted this cycle
- mem_wr_en  out  1  vertex memory write enable
- mem_wr_addr  out  AW  vertex memory write address
- mem_wr_data  out  M+N  vertex memory write data
- gpu_vertex_count  out  32  active vertex count
- gpu_start  out  1  GPU start pulse
- transform_matrix  out  16 x (M+N)  active matrix, signed, unpacked array [0:15]
- frame_end  in  1  rasterizer frame-complete pulse
- busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle end-of-frame pulse
- frame_error  out  1  one-cycle pulse with frame_done on zero-count or timeout
- frame_cnt  out  16  successfully completed frames; wraps at 65535 -> 0
- last_frame_cycles  out  32  cycles from START to DONE of the last frame, saturating

Behaviour:
- Reset (asynchronous, while reset=0): state = IDLE; all outputs 0, including the active matrix, gpu_vertex_count, frame_cnt and last_frame_cycles; staging matrix cleared to 0. Reset mid-frame aborts the frame with no frame_done.
- Staging writes: a cfg_mat_wr_en write updates staging[cfg_mat_wr_idx] in any state and never disturbs the active matrix.
- IDLE: frame_req=1 -> LATCH.
- LATCH (1 cycle):
  - frame_ack=1.
  - Active matrix <= staging. If a staging write lands in the same cycle, the new value is copied.
  - gpu_vertex_count <= cfg_vertex_count & 32'hFFFFFFFC.
  - Masked count == 0 -> DONE with error flag set; otherwise -> START.
- START (1 cycle): gpu_start=1. The cycle counter and xform counter load here; xform counter <= count + XFORM_LAT. -> TRANSFORM.
- TRANSFORM: xform counter decrements each cycle; at 0 -> RASTER. frame_end is ignored in this state.
- RASTER:
  - frame_end=1 -> DONE.
  - Watchdog reaches TIMEOUT -> DONE with error flag set.
  - frame_end arriving in the same cycle as the timeout is treated as success.
- DONE (1 cycle):
  - frame_done=1; frame_error = error flag.
  - frame_cnt increments only when there is no error.
  - last_frame_cycles updates in both cases.
  - -> IDLE. frame_req still high in IDLE starts the next frame (back-to-back frames allowed).
- gpu_start, frame_ack, frame_done and frame_error are decoded from the registered state, so they are glitch-free.
- Host write arbitration:
  - host_wr_ready = 1 in IDLE, RASTER and DONE; 0 in LATCH, START and TRANSFORM.
  - A write is accepted when host_wr_en & host_wr_ready.
  - mem_wr_* are registered: the write appears 1 cycle after acceptance, with mem_wr_en=1 for exactly 1 cycle.
  - A rejected write must be held by the host until it is accepted.
- Active outputs (matrix, count) stay stable from LATCH until the next LATCH.

Test Plan:
- Staging writes idx 0..15 = k*128, cfg_vertex_count=10, frame_req pulse -> frame_ack 1 cycle later; gpu_vertex_count=8; gpu_start 1 cycle after ack; TRANSFORM lasts 8+16=24 cycles; matrix matches staging.
- Frame running, frame_end 50 cycles into RASTER -> frame_done=1, frame_error=0, frame_cnt 0->1; last_frame_cycles = 1+24+50+1 (±1 per the counting definition in the implementation).
- cfg_vertex_count=3 -> masked to 0; gpu_start never asserts; frame_done and frame_error both pulse; frame_cnt unchanged.
- host_wr_en held high during TRANSFORM -> host_wr_ready=0 and no mem_wr_en; write lands 1 cycle after entry to RASTER with the same addr/data.
- TIMEOUT=100, no frame_end -> frame_error after 100 RASTER cycles. Then assert reset mid-TRANSFORM -> all outputs 0 immediately, no frame_done; frame_req after release restarts cleanly.
